aggr_scheduler: RTL and testbench

//  Sequences the GAT aggregation datapath: walks the WH BRAM one node-group at a time
//  and paces alpha FIFO pops against WH row reads. Emits first/last/valid tokens aligned
//  to the multiplier output, and generates new-feature BRAM write strobes and addresses.

---
 rtl/aggr_scheduler_pkg.sv | 26 ++
 rtl/aggr_scheduler_if.sv | 61 ++++++
 rtl/aggr_tok_pipe.sv | 33 +++
 rtl/aggr_scheduler.sv | 148 ++++++++++++++
 tb/tb_aggr_scheduler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/aggr_scheduler_pkg.sv
// Shared types and sizes for the GAT aggregation scheduler.
// Optional AGGR_SCHED_PERF_EN adds the perf counters in the top and interface.
package aggr_scheduler_pkg;

  localparam int NUM_NODE_WIDTH     = 8;
  localparam int WH_ADDR_W          = 10;
  localparam int NEW_FEATURE_ADDR_W = 6;
  localparam int MUL_LATENCY        = 2;
  localparam int TOK_DEPTH          = 1 + MUL_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_RD,
    S_HDR_CHK,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } mac_tok_t;

endpackage

// File: rtl/aggr_scheduler_if.sv
// Scheduler control/BRAM/FIFO/MAC bundle.
// AGGR_SCHED_PERF_EN adds perf_cycle_o / perf_stall_o.
interface aggr_scheduler_if;
  import aggr_scheduler_pkg::*;

  logic                          start_i;
  logic [NUM_NODE_WIDTH-1:0]     num_nodes_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          err_o;
  logic [WH_ADDR_W-1:0]          wh_addr_o;
  logic                          wh_hdr_flag_i;
  logic [NUM_NODE_WIDTH-1:0]     wh_hdr_cnt_i;
  logic                          alpha_empty_i;
  logic                          alpha_rd_o;
  logic                          mac_vld_o;
  logic                          mac_first_o;
  logic                          mac_last_o;
  logic                          fea_we_o;
  logic [NEW_FEATURE_ADDR_W-1:0] fea_addr_o;

`ifdef AGGR_SCHED_PERF_EN
  logic [31:0] perf_cycle_o;
  logic [31:0] perf_stall_o;

  modport slave (
    input  start_i, num_nodes_i, wh_hdr_flag_i,
    input  wh_hdr_cnt_i, alpha_empty_i,
    output busy_o, done_o, err_o, wh_addr_o,
    output alpha_rd_o, mac_vld_o, mac_first_o,
    output mac_last_o, fea_we_o, fea_addr_o,
    output perf_cycle_o, perf_stall_o
  );

  modport master (
    output start_i, num_nodes_i, wh_hdr_flag_i,
    output wh_hdr_cnt_i, alpha_empty_i,
    input  busy_o, done_o, err_o, wh_addr_o,
    input  alpha_rd_o, mac_vld_o, mac_first_o,
    input  mac_last_o, fea_we_o, fea_addr_o,
    input  perf_cycle_o, perf_stall_o
  );
`else
  modport slave (
    input  start_i, num_nodes_i, wh_hdr_flag_i,
    input  wh_hdr_cnt_i, alpha_empty_i,
    output busy_o, done_o, err_o, wh_addr_o,
    output alpha_rd_o, mac_vld_o, mac_first_o,
    output mac_last_o, fea_we_o, fea_addr_o
  );

  modport master (
    output start_i, num_nodes_i, wh_hdr_flag_i,
    output wh_hdr_cnt_i, alpha_empty_i,
    input  busy_o, done_o, err_o, wh_addr_o,
    input  alpha_rd_o, mac_vld_o, mac_first_o,
    input  mac_last_o, fea_we_o, fea_addr_o
  );
`endif

endinterface

// File: rtl/aggr_tok_pipe.sv
// Token delay line aligning first/last/valid with the multiplier output.
module aggr_tok_pipe
  import aggr_scheduler_pkg::*;
#(
  parameter int DEPTH = TOK_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mac_tok_t tok_in,
  output mac_tok_t tok_out,
  output logic     empty
);

  mac_tok_t [DEPTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg <= {stg[DEPTH-2:0], tok_in};
    end
  end

  assign tok_out = stg[DEPTH-1];

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (stg[i].vld) empty = 1'b0;
    end
  end

endmodule

// File: rtl/aggr_scheduler.sv
// GAT aggregation sequencer: WH walk, alpha pacing, MAC tokens, feature writes.
// Define AGGR_SCHED_PERF_EN for busy/stall cycle counters.
module aggr_scheduler
  import aggr_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  aggr_scheduler_if.slave bus
);

  localparam logic [NUM_NODE_WIDTH-1:0]     ONE_N = 1;
  localparam logic [WH_ADDR_W-1:0]          ONE_W = 1;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] ONE_F = 1;

  sched_state_e                  state;
  logic [NUM_NODE_WIDTH-1:0]     nodes, node, rem, cnt;
  logic [WH_ADDR_W-1:0]          wh_addr;
  logic [NEW_FEATURE_ADDR_W-1:0] fea_addr;
  logic                          err, busy, done, fea_we;
  logic                          pop, hdr_ok, last_node, pipe_empty;
  logic [NUM_NODE_WIDTH-1:0]     node_nx;
  mac_tok_t                      tok_in, tok_out;

  assign pop       = (state == S_STREAM) && !bus.alpha_empty_i;
  assign hdr_ok    = bus.wh_hdr_flag_i && (bus.wh_hdr_cnt_i != '0);
  assign node_nx   = node + ONE_N;
  assign last_node = (node_nx == nodes);

  always_comb begin
    tok_in       = '0;
    tok_in.vld   = pop;
    tok_in.first = pop && (rem == cnt);
    tok_in.last  = pop && (rem == ONE_N);
  end

  aggr_tok_pipe #(.DEPTH(TOK_DEPTH)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tok_in  (tok_in),
    .tok_out (tok_out),
    .empty   (pipe_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      nodes    <= '0;
      node     <= '0;
      rem      <= '0;
      cnt      <= '0;
      wh_addr  <= '0;
      fea_addr <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fea_we   <= 1'b0;
    end else begin
      // write lands one cycle after the last product (accumulator register)
      fea_we <= tok_out.vld & tok_out.last;
      if (fea_we) fea_addr <= fea_addr + ONE_F;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            nodes    <= bus.num_nodes_i;
            node     <= '0;
            wh_addr  <= '0;
            fea_addr <= '0;
            err      <= 1'b0;
            if (bus.num_nodes_i == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_HDR_RD;
              busy  <= 1'b1;
            end
          end
        end
        S_HDR_RD: state <= S_HDR_CHK;
        S_HDR_CHK: begin
          if (hdr_ok) begin
            rem   <= bus.wh_hdr_cnt_i;
            cnt   <= bus.wh_hdr_cnt_i;
            state <= S_STREAM;
          end else begin
            err     <= 1'b1;
            wh_addr <= wh_addr + ONE_W;
            node    <= node_nx;
            state   <= last_node ? S_DRAIN : S_HDR_RD;
          end
        end
        S_STREAM: begin
          if (pop) begin
            wh_addr <= wh_addr + ONE_W;
            rem     <= rem - ONE_N;
            if (rem == ONE_N) begin
              node  <= node_nx;
              state <= last_node ? S_DRAIN : S_HDR_RD;
            end
          end
        end
        S_DRAIN: begin
          if (pipe_empty && !fea_we) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AGGR_SCHED_PERF_EN
  logic [31:0] perf_cycle, perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle <= '0;
      perf_stall <= '0;
    end else if (state == S_IDLE && bus.start_i) begin
      perf_cycle <= '0;
      perf_stall <= '0;
    end else begin
      if (busy && !(&perf_cycle))
        perf_cycle <= perf_cycle + 32'd1;
      if (state == S_STREAM && bus.alpha_empty_i && !(&perf_stall))
        perf_stall <= perf_stall + 32'd1;
    end
  end

  assign bus.perf_cycle_o = perf_cycle;
  assign bus.perf_stall_o = perf_stall;
`endif

  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.err_o       = err;
  assign bus.wh_addr_o   = wh_addr;
  assign bus.alpha_rd_o  = pop;
  assign bus.mac_vld_o   = tok_out.vld;
  assign bus.mac_first_o = tok_out.first;
  assign bus.mac_last_o  = tok_out.last;
  assign bus.fea_we_o    = fea_we;
  assign bus.fea_addr_o  = fea_addr;

endmodule

// File: tb/tb_aggr_scheduler.sv
// Directed bench for aggr_scheduler with a 1-cycle WH BRAM model.
// Perf checks compile in when AGGR_SCHED_PERF_EN is defined.
module tb_aggr_scheduler;
  import aggr_scheduler_pkg::*;

  localparam int LOGN = 512;
  localparam int B_RD = 0, B_MV = 1, B_MF = 2, B_ML = 3;
  localparam int B_WE = 4, B_DN = 5, B_BS = 6, B_ER = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   stall_from = 0, stall_to = 0;
  int   n_cmp = 0, n_bad = 0;

  logic [7:0]                    flg_log [LOGN];
  logic [WH_ADDR_W-1:0]          wa_log  [LOGN];
  logic [NEW_FEATURE_ADDR_W-1:0] fa_log  [LOGN];
  logic                          mem_flag [16];
  logic [NUM_NODE_WIDTH-1:0]     mem_cnt  [16];

  aggr_scheduler_if bus();

  aggr_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    bus.wh_hdr_flag_i <= mem_flag[bus.wh_addr_o[3:0]];
    bus.wh_hdr_cnt_i  <= mem_cnt[bus.wh_addr_o[3:0]];
  end

  always_comb bus.alpha_empty_i = (cyc >= stall_from) && (cyc < stall_to);

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      flg_log[cyc] = {bus.err_o, bus.busy_o, bus.done_o, bus.fea_we_o,
                      bus.mac_last_o, bus.mac_first_o, bus.mac_vld_o,
                      bus.alpha_rd_o};
      wa_log[cyc]  = bus.wh_addr_o;
      fa_log[cyc]  = bus.fea_addr_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt(input int b, input int a, input int z);
    int n = 0;
    for (int i = a; i <= z; i++) if (flg_log[i][b] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic [2:0] mac_at(input int c);
    return {flg_log[c][B_MV], flg_log[c][B_MF], flg_log[c][B_ML]};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int n, output int t0);
    @(posedge clk);
    #1;
    bus.num_nodes_i = NUM_NODE_WIDTH'(n);
    bus.start_i     = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic set_hdr(input int a, input logic f, input int c);
    mem_flag[a] = f;
    mem_cnt[a]  = NUM_NODE_WIDTH'(c);
  endtask

  initial begin
    int t0, t1;
    int pc[4], pa[4];
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.num_nodes_i = '0;
    for (int i = 0; i < 16; i++) set_hdr(i, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", 32'(flg_log[cyc]), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wh_addr", 32'(bus.wh_addr_o), 0);
    chk("rst_fea_addr", 32'(bus.fea_addr_o), 0);
    chk("rst_outs", {bus.busy_o, bus.done_o, bus.alpha_rd_o, bus.fea_we_o}, 0);

    // T1: two nodes, N=3 at row 0 then N=1 at row 3
    set_hdr(0, 1'b1, 3);
    set_hdr(3, 1'b1, 1);
    start_pass(2, t0);
    wait_cyc(18);
    pc = '{3, 4, 5, 8};
    pa = '{0, 1, 2, 3};
    chk("t1_hdr0_addr", 32'(wa_log[t0+1]), 0);
    chk("t1_hdr1_addr", 32'(wa_log[t0+6]), 3);
    chk("t1_pops", cnt(B_RD, t0, t0+17), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pop%0d", i), 32'(flg_log[t0+pc[i]][B_RD]), 1);
      chk($sformatf("t1_pop%0d_addr", i), 32'(wa_log[t0+pc[i]]), pa[i]);
    end
    chk("t1_mac_vld_cnt", cnt(B_MV, t0, t0+17), 4);
    chk("t1_mac_p1", 32'(mac_at(t0+6)), 3'b110);
    chk("t1_mac_p2", 32'(mac_at(t0+7)), 3'b100);
    chk("t1_mac_p3", 32'(mac_at(t0+8)), 3'b101);
    chk("t1_mac_p4", 32'(mac_at(t0+11)), 3'b111);
    chk("t1_we_cnt", cnt(B_WE, t0, t0+17), 2);
    chk("t1_we0", 32'({flg_log[t0+9][B_WE], fa_log[t0+9]}), {1'b1, 6'd0});
    chk("t1_we1", 32'({flg_log[t0+12][B_WE], fa_log[t0+12]}), {1'b1, 6'd1});
    chk("t1_busy_pre_done", 32'(flg_log[t0+13][B_BS]), 1);
    chk("t1_done", 32'({flg_log[t0+14][B_DN], flg_log[t0+14][B_BS]}), 2'b10);
    chk("t1_done_cnt", cnt(B_DN, t0, t0+17), 1);

    // T2: one node N=4, FIFO empty for two cycles after the 2nd pop
    set_hdr(0, 1'b1, 4);
    start_pass(1, t0);
    stall_from = t0 + 5;
    stall_to   = t0 + 7;
    wait_cyc(18);
    chk("t2_hold_a", 32'(wa_log[t0+5]), 2);
    chk("t2_hold_b", 32'(wa_log[t0+6]), 2);
    chk("t2_no_pop_stall", cnt(B_RD, t0+5, t0+6), 0);
    chk("t2_pops", cnt(B_RD, t0, t0+17), 4);
    chk("t2_mac_vld_cnt", cnt(B_MV, t0, t0+17), 4);
    chk("t2_mac_first", 32'(mac_at(t0+6)), 3'b110);
    chk("t2_no_bubble", 32'(mac_at(t0+9)), 3'b000);
    chk("t2_mac_p3", 32'(mac_at(t0+10)), 3'b100);
    chk("t2_mac_last", 32'(mac_at(t0+11)), 3'b101);
    chk("t2_we", 32'({flg_log[t0+12][B_WE], fa_log[t0+12]}), {1'b1, 6'd0});
    chk("t2_done", 32'(flg_log[t0+14][B_DN]), 1);
`ifdef AGGR_SCHED_PERF_EN
    chk("t2_perf_stall", bus.perf_stall_o, 2);
    chk("t2_perf_cycle", bus.perf_cycle_o, 13);
`endif

    // T3: bad header at row 0, good N=2 header at row 1
    set_hdr(0, 1'b0, 3);
    set_hdr(1, 1'b1, 2);
    start_pass(2, t0);
    wait_cyc(16);
    chk("t3_err_clear", 32'(flg_log[t0+1][B_ER]), 0);
    chk("t3_err_set", 32'(flg_log[t0+3][B_ER]), 1);
    chk("t3_hdr1_addr", 32'(wa_log[t0+3]), 1);
    chk("t3_pop_addr", 32'({flg_log[t0+5][B_RD], wa_log[t0+5]}), {1'b1, 10'd1});
    chk("t3_pops", cnt(B_RD, t0, t0+15), 2);
    chk("t3_mac_last", 32'(mac_at(t0+9)), 3'b101);
    chk("t3_we_cnt", cnt(B_WE, t0, t0+15), 1);
    chk("t3_done", 32'(flg_log[t0+12][B_DN]), 1);
    chk("t3_err_sticky", 32'(flg_log[t0+15][B_ER]), 1);

    // T4: zero nodes
    start_pass(0, t0);
    wait_cyc(6);
    chk("t4_done", 32'({flg_log[t0+1][B_DN], flg_log[t0+1][B_BS]}), 2'b10);
    chk("t4_err_clear", 32'(flg_log[t0+1][B_ER]), 0);
    chk("t4_no_pop", cnt(B_RD, t0, t0+5), 0);
    chk("t4_no_we", cnt(B_WE, t0, t0+5), 0);
    chk("t4_done_cnt", cnt(B_DN, t0, t0+5), 1);

    // T6: start pulsed while busy is ignored
    set_hdr(0, 1'b1, 2);
    set_hdr(2, 1'b1, 5);
    start_pass(1, t0);
    wait_cyc(2);
    bus.num_nodes_i = NUM_NODE_WIDTH'(3);
    bus.start_i     = 1'b1;
    wait_cyc(1);
    bus.start_i = 1'b0;
    wait_cyc(17);
    chk("t6_busy_mid", 32'(flg_log[t0+5][B_BS]), 1);
    chk("t6_pops", cnt(B_RD, t0, t0+19), 2);
    chk("t6_we_cnt", cnt(B_WE, t0, t0+19), 1);
    chk("t6_done", 32'(flg_log[t0+10][B_DN]), 1);
    chk("t6_done_cnt", cnt(B_DN, t0, t0+19), 1);

    // T5: reset mid-stream, then a clean restart
    set_hdr(0, 1'b1, 4);
    start_pass(1, t0);
    wait_cyc(3);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    chk("t5_was_stream", 32'(flg_log[t0+3][B_RD]), 1);
    chk("t5_rst_flags", 32'(flg_log[t0+4]), 0);
    chk("t5_rst_addr", 32'(wa_log[t0+4]), 0);
    set_hdr(0, 1'b1, 1);
    wait_cyc(2);
    start_pass(1, t1);
    wait_cyc(12);
    chk("t5_dropped_toks", cnt(B_MV, t0+4, t1+5), 0);
    chk("t5_pop_addr", 32'({flg_log[t1+3][B_RD], wa_log[t1+3]}), {1'b1, 10'd0});
    chk("t5_mac", 32'(mac_at(t1+6)), 3'b111);
    chk("t5_we", 32'({flg_log[t1+7][B_WE], fa_log[t1+7]}), {1'b1, 6'd0});
    chk("t5_done", 32'(flg_log[t1+9][B_DN]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
